// File: rtl/readout_pkg.sv
// readout_pkg
//   Shared types and helpers for the column readout receiver.
//   rx_state_t : receiver FSM states.
//   cntWidth() : bit width of a counter/index covering 0..n-1 (minimum 1).
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        FLUSH,
        DONE
    } rx_state_t;

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/col_deser.sv
// col_deser
//   Per-column deserializer for the A and B counter chains.
//   Ports:
//     readClk, reset   clock, synchronous active-high reset
//     shiftEn          chains shift this edge; serA/serB are sampled
//     load             copy the (post-shift) shift registers into the hold
//     serA, serB       serial chain outputs, MSB first
//     holdA, holdB     held pixel counter words
//     sumAB            holdA + holdB, full width
module col_deser #(
    parameter int CNT_W = 12
) (
    input  logic             readClk,
    input  logic             reset,
    input  logic             shiftEn,
    input  logic             load,
    input  logic             serA,
    input  logic             serB,
    output logic [CNT_W-1:0] holdA,
    output logic [CNT_W-1:0] holdB,
    output logic [CNT_W:0]   sumAB
);

    logic [CNT_W-1:0] shA, shB;
    logic [CNT_W-1:0] shANext, shBNext;

    // The hold loads from the next-state value so the bit sampled on the
    // completing edge is included; when loading with shifting paused the
    // shift register already holds the complete word.
    assign shANext = shiftEn ? {shA[CNT_W-2:0], serA} : shA;
    assign shBNext = shiftEn ? {shB[CNT_W-2:0], serB} : shB;

    always_ff @(posedge readClk) begin
        if (reset) begin
            shA   <= '0;
            shB   <= '0;
            holdA <= '0;
            holdB <= '0;
        end else begin
            shA <= shANext;
            shB <= shBNext;
            if (load) begin
                holdA <= shANext;
                holdB <= shBNext;
            end
        end
    end

    assign sumAB = {1'b0, holdA} + {1'b0, holdB};

endmodule

// File: rtl/col_readout_rx.sv
// col_readout_rx
//   Receive end of the pixel-array column serial readout chains. Shifts all
//   columns in lockstep, deserializes each row group into a hold buffer and
//   streams per-pixel words out over valid/ready.
//   Ports:
//     readClk, reset      clock, synchronous active-high reset
//     start, sum_mode     frame start pulse; sum mode latched at start
//     ser_a, ser_b        per-column serial chain outputs
//     shift_en, busy      chain shift enable, frame in progress
//     m_valid/m_ready     output stream handshake
//     m_data/m_row/m_col/m_sel/m_last  word payload
//     frame_done          one-cycle pulse after the final word
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | chains shifting, one bit per cycle
//   WAIT  | row group complete but hold still draining; shifting paused
//   FLUSH | all rows captured, draining the last group
//   DONE  | frame finished, frame_done high for this cycle
module col_readout_rx
    import readout_pkg::*;
#(
    parameter int ROW   = 3,
    parameter int COL   = 3,
    parameter int CNT_W = 12
) (
    input  logic                     readClk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sum_mode,
    input  logic [COL-1:0]           ser_a,
    input  logic [COL-1:0]           ser_b,
    output logic                     shift_en,
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CNT_W:0]           m_data,
    output logic [cntWidth(ROW)-1:0] m_row,
    output logic [cntWidth(COL)-1:0] m_col,
    output logic                     m_sel,
    output logic                     m_last,
    output logic                     frame_done
);

    localparam int RW = cntWidth(ROW);
    localparam int CW = cntWidth(COL);
    localparam int BW = cntWidth(CNT_W);
    localparam int WW = cntWidth(2 * COL);
    localparam logic [BW-1:0] BIT_LAST = BW'(CNT_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

    rx_state_t        state;
    logic [BW-1:0]    bitCnt;
    logic [RW-1:0]    rowCnt;
    logic [RW-1:0]    holdRow;
    logic [WW-1:0]    wordCnt;
    logic [WW-1:0]    wordLast;
    logic             holdValid;
    logic             sumLat;
    logic             xfer;
    logic             holdFree;
    logic             bitWrap;
    logic             loadHold;
    logic [CW-1:0]    colIdx;

    logic [CNT_W-1:0] holdA [COL];
    logic [CNT_W-1:0] holdB [COL];
    logic [CNT_W:0]   sumAB [COL];

    for (genvar c = 0; c < COL; c++) begin : g_col
        col_deser #(.CNT_W(CNT_W)) uDeser (
            .readClk (readClk),
            .reset   (reset),
            .shiftEn (shift_en),
            .load    (loadHold),
            .serA    (ser_a[c]),
            .serB    (ser_b[c]),
            .holdA   (holdA[c]),
            .holdB   (holdB[c]),
            .sumAB   (sumAB[c])
        );
    end

    assign shift_en   = (state == SHIFT);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign m_valid    = holdValid;

    assign wordLast = sumLat ? WW'(COL - 1) : WW'(2 * COL - 1);
    assign xfer     = holdValid && m_ready;
    // The hold can accept a new group in the same edge its last word leaves.
    assign holdFree = !holdValid || (xfer && (wordCnt == wordLast));
    assign bitWrap  = shift_en && (bitCnt == BIT_LAST);
    assign loadHold = ((state == SHIFT && bitWrap) || state == WAIT) && holdFree;

    always_comb begin
        colIdx = sumLat ? CW'(wordCnt) : CW'(wordCnt >> 1);
        m_sel  = !sumLat && wordCnt[0];
        m_col  = colIdx;
        m_row  = holdRow;
        if (sumLat)
            m_data = sumAB[colIdx];
        else if (m_sel)
            m_data = {1'b0, holdB[colIdx]};
        else
            m_data = {1'b0, holdA[colIdx]};
        m_last = holdValid && (holdRow == ROW_LAST) && (wordCnt == wordLast);
    end

    always_ff @(posedge readClk) begin
        if (reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            rowCnt    <= '0;
            holdRow   <= '0;
            wordCnt   <= '0;
            holdValid <= 1'b0;
            sumLat    <= 1'b0;
        end else begin
            if (shift_en)
                bitCnt <= bitWrap ? '0 : bitCnt + 1'b1;

            if (loadHold) begin
                holdValid <= 1'b1;
                wordCnt   <= '0;
                holdRow   <= rowCnt;
            end else if (xfer) begin
                if (wordCnt == wordLast) begin
                    holdValid <= 1'b0;
                    wordCnt   <= '0;
                end else begin
                    wordCnt <= wordCnt + 1'b1;
                end
            end

            // rowCnt names the group sitting in the shift registers; it
            // advances only once that group has moved into the hold.
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SHIFT;
                        sumLat <= sum_mode;
                        rowCnt <= '0;
                        bitCnt <= '0;
                    end
                end
                SHIFT: begin
                    if (bitWrap) begin
                        if (!holdFree)
                            state <= WAIT;
                        else if (rowCnt == ROW_LAST)
                            state <= FLUSH;
                        else
                            rowCnt <= rowCnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (holdFree) begin
                        if (rowCnt == ROW_LAST) begin
                            state <= FLUSH;
                        end else begin
                            rowCnt <= rowCnt + 1'b1;
                            state  <= SHIFT;
                        end
                    end
                end
                FLUSH: begin
                    if (holdFree)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_col_readout_rx.sv
// tb_col_readout_rx
//   Self-checking bench for col_readout_rx (ROW=3, COL=3, CNT_W=12).
//   Chains are modelled as bit streams driven on the falling edge; words are
//   scoreboarded against an expected queue built from the pixel values.
module tb_col_readout_rx;

    localparam int ROW   = 3;
    localparam int COL   = 3;
    localparam int CNT_W = 12;
    localparam int NBITS = ROW * CNT_W;

    logic             readClk = 1'b0;
    logic             reset, start, sum_mode, m_ready;
    logic [COL-1:0]   ser_a, ser_b;
    logic             shift_en, busy, m_valid, m_sel, m_last, frame_done;
    logic [CNT_W:0]   m_data;
    logic [1:0]       m_row, m_col;

    always #5 readClk = ~readClk;

    col_readout_rx #(.ROW(ROW), .COL(COL), .CNT_W(CNT_W)) dut (
        .readClk    (readClk),
        .reset      (reset),
        .start      (start),
        .sum_mode   (sum_mode),
        .ser_a      (ser_a),
        .ser_b      (ser_b),
        .shift_en   (shift_en),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_sel      (m_sel),
        .m_last     (m_last),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic           last;
        logic           sel;
        logic [1:0]     col;
        logic [1:0]     row;
        logic [CNT_W:0] data;
    } word_t;

    typedef struct {
        int pattern;       // 0 = 0x100/0xA00 ramp, 1 = all 0xFFF, 2 = random
        bit sumM;
        int readyM;        // 0 = always ready, 1 = 20-cycle stall, 2 = random
        int startAgainAt;  // cycle of a spurious start pulse, -1 none
        int expWords;
        int expMaxRun;     // longest shift_en run, -1 = not checked
        int expFirst;
        int expLast;
    } vec_t;

    vec_t             vecs[5];
    word_t            expQ[$];
    logic [CNT_W-1:0] pixA [ROW][COL];
    logic [CNT_W-1:0] pixB [ROW][COL];

    int checks = 0;
    int errors = 0;
    int ptr, cyc, readyMode, stallLeft;
    bit firstValidSeen, prevShift, stalled;
    int shiftTotal, shiftRun, shiftMaxRun, wordsGot, lastHsCyc, doneCyc, activity;
    logic [CNT_W:0] firstData, lastData;
    word_t snap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic newFrame(input int pattern, input bit sumM);
        expQ.delete();
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                case (pattern)
                    0: begin
                        pixA[r][c] = CNT_W'(12'h100 + 16 * r + c);
                        pixB[r][c] = CNT_W'(12'hA00 + 16 * r + c);
                    end
                    1: begin
                        pixA[r][c] = 12'hFFF;
                        pixB[r][c] = 12'hFFF;
                    end
                    default: begin
                        pixA[r][c] = CNT_W'($urandom);
                        pixB[r][c] = CNT_W'($urandom);
                    end
                endcase
            end
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                if (sumM) begin
                    expQ.push_back('{last: (r == ROW-1 && c == COL-1), sel: 1'b0,
                                     col: 2'(c), row: 2'(r),
                                     data: {1'b0, pixA[r][c]} + {1'b0, pixB[r][c]}});
                end else begin
                    expQ.push_back('{last: 1'b0, sel: 1'b0, col: 2'(c), row: 2'(r),
                                     data: {1'b0, pixA[r][c]}});
                    expQ.push_back('{last: (r == ROW-1 && c == COL-1), sel: 1'b1,
                                     col: 2'(c), row: 2'(r), data: {1'b0, pixB[r][c]}});
                end
            end
    endtask

    // One clock: wait for the falling edge, drive chains and m_ready for the
    // next rising edge, then check whatever the DUT is presenting.
    task automatic cycle();
        word_t cur, e;
        @(negedge readClk);
        cyc++;
        if (prevShift) ptr++;
        for (int c = 0; c < COL; c++) begin
            if (ptr < NBITS) begin
                ser_a[c] = pixA[ptr / CNT_W][c][CNT_W - 1 - (ptr % CNT_W)];
                ser_b[c] = pixB[ptr / CNT_W][c][CNT_W - 1 - (ptr % CNT_W)];
            end else begin
                ser_a[c] = 1'($urandom_range(1, 0));
                ser_b[c] = 1'($urandom_range(1, 0));
            end
        end
        prevShift = shift_en;
        if (shift_en) begin
            shiftTotal++;
            shiftRun++;
            if (shiftRun > shiftMaxRun) shiftMaxRun = shiftRun;
        end else begin
            shiftRun = 0;
        end
        if (m_valid || shift_en || busy) activity++;

        case (readyMode)
            0: m_ready = 1'b1;
            1: begin
                if (m_valid && !firstValidSeen) begin
                    firstValidSeen = 1'b1;
                    stallLeft = 20;
                end
                if (stallLeft > 0) begin
                    m_ready = 1'b0;
                    stallLeft--;
                end else begin
                    m_ready = 1'b1;
                end
            end
            default: m_ready = 1'($urandom_range(1, 0));
        endcase

        cur = '{last: m_last, sel: m_sel, col: m_col, row: m_row, data: m_data};
        if (stalled) check("stall_hold", {m_valid, cur}, {1'b1, snap});
        if (m_valid && m_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word actual=%0h required=none", cur);
            end else begin
                e = expQ.pop_front();
                check($sformatf("word%0d", wordsGot), cur, e);
            end
            if (wordsGot == 0) firstData = m_data;
            lastData  = m_data;
            wordsGot++;
            lastHsCyc = cyc;
        end
        stalled = m_valid && !m_ready;
        snap    = cur;
        if (frame_done && doneCyc < 0) doneCyc = cyc;
    endtask

    task automatic startFrame(input int pattern, input bit sumM, input int readyM);
        newFrame(pattern, sumM);
        readyMode = readyM;
        firstValidSeen = 1'b0;
        stallLeft = 0;
        shiftTotal = 0; shiftRun = 0; shiftMaxRun = 0;
        wordsGot = 0; lastHsCyc = -10; doneCyc = -1;
        stalled = 1'b0; ptr = 0; prevShift = 1'b0;
        sum_mode = sumM;
        start = 1'b1;
        cycle();
        start = 1'b0;
        sum_mode = ~sumM;   // mid-frame change must be ignored
    endtask

    task automatic runFrame(input vec_t v);
        int n;
        startFrame(v.pattern, v.sumM, v.readyM);
        n = 0;
        while (doneCyc < 0 && n < 3000) begin
            if (n == v.startAgainAt) start = 1'b1;
            cycle();
            start = 1'b0;
            n++;
        end
        if (doneCyc < 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual=%0d cycles required=frame_done", n);
        end
        check("word_count", wordsGot, v.expWords);
        check("shift_total", shiftTotal, NBITS);
        check("done_latency", doneCyc, lastHsCyc + 1);
        if (v.expMaxRun >= 0) check("shift_run", shiftMaxRun, v.expMaxRun);
        if (v.expFirst >= 0) begin
            check("first_data", firstData, v.expFirst);
            check("last_data", lastData, v.expLast);
        end
        cycle();
        check("idle_after_done", {busy, frame_done, m_valid, shift_en}, 4'b0000);
    endtask

    initial begin
        vec_t rv;

        vecs[0] = '{0, 1'b0, 0, -1, 18, 36, 'h100,  'hA22};
        vecs[1] = '{1, 1'b1, 0, -1,  9, 36, 'h1FFE, 'h1FFE};
        vecs[2] = '{0, 1'b0, 1, -1, 18, 24, 'h100,  'hA22};
        vecs[3] = '{0, 1'b0, 0, 10, 18, 36, 'h100,  'hA22};
        vecs[4] = '{0, 1'b1, 0, -1,  9, 36, 'hB00,  'hB44};

        reset = 1'b1; start = 1'b0; sum_mode = 1'b0; m_ready = 1'b0;
        ser_a = '0; ser_b = '0;
        cyc = 0; ptr = NBITS; prevShift = 1'b0; stalled = 1'b0;
        readyMode = 0; wordsGot = 0; doneCyc = -1; activity = 0;

        // Reset with random chain activity.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("reset_outputs",
                  {shift_en, busy, m_valid, m_last, frame_done, m_sel, m_row, m_col, m_data},
                  '0);
        end
        reset = 1'b0;
        activity = 0;
        for (int i = 0; i < 20; i++) cycle();
        check("no_start_activity", activity, 0);

        // Directed frames.
        for (int i = 0; i < 5; i++) runFrame(vecs[i]);

        // Reset in the middle of a frame.
        startFrame(0, 1'b0, 0);
        for (int i = 0; i < 14; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midreset_outputs", {m_valid, shift_en, busy}, 3'b000);
        expQ.delete();
        activity = 0;
        for (int i = 0; i < 20; i++) cycle();
        check("midreset_quiet", activity, 0);
        runFrame(vecs[0]);

        // Random data, random back-pressure.
        for (int f = 0; f < 20; f++) begin
            rv.pattern = 2;
            rv.sumM = 1'($urandom_range(1, 0));
            rv.readyM = 2;
            rv.startAgainAt = -1;
            rv.expWords = rv.sumM ? ROW * COL : 2 * ROW * COL;
            rv.expMaxRun = -1;
            rv.expFirst = -1;
            rv.expLast = -1;
            runFrame(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
